// File: rtl/video_pkg.sv
`default_nettype none
// video_pkg: shared pixel types, blend-mode and compositor-state encodings.
// Revision: 1.0
package video_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic [1:0] {
    BLEND_OPAQUE = 2'd0,
    BLEND_75     = 2'd1,
    BLEND_50     = 2'd2,
    BLEND_25     = 2'd3
  } blend_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_LATCHED = 1'b1
  } comp_state_e;

  // 10-bit intermediates hold 3*255+255 without overflow; results truncate.
  function automatic logic [7:0] blend_ch(input logic [7:0] f, input logic [7:0] b,
                                          input blend_e mode);
    logic [9:0] f10;
    logic [9:0] b10;
    logic [9:0] s;
    f10 = {2'b00, f};
    b10 = {2'b00, b};
    case (mode)
      BLEND_75: s = ((f10 << 1) + f10 + b10) >> 2;
      BLEND_50: s = (f10 + b10) >> 1;
      BLEND_25: s = (f10 + (b10 << 1) + b10) >> 2;
      default:  s = f10;
    endcase
    return 8'(s);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_delay.sv
`default_nettype none
// pipe_delay: STAGES-deep register shift line, asynchronous active-low clear.
// Revision: 1.0
module pipe_delay #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) r_stage[s] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int s = 1; s < STAGES; s++) r_stage[s] <= r_stage[s-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/sprite_compositor.sv
`default_nettype none
// sprite_compositor: aligns timing to late sprite RGB, applies colour key and
// frame-synchronous blend, registers RGB + timing for the encoder. Revision: 1.0
module sprite_compositor
  import video_pkg::*;
#(
  parameter int SPRITE_LATENCY = 4,
  parameter int H_WIDTH        = 11,
  parameter int V_WIDTH        = 10
) (
  input  logic               pixel_clk_in,
  input  logic               rst_n_in,
  input  logic [H_WIDTH-1:0] hcount_in,
  input  logic [V_WIDTH-1:0] vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               active_in,
  input  logic [23:0]        bg_rgb_in,
  input  logic [23:0]        fg_rgb_in,
  input  logic [23:0]        key_rgb_in,
  input  logic               key_en_in,
  input  logic [1:0]         blend_in,
  output logic [H_WIDTH-1:0] hcount_out,
  output logic [V_WIDTH-1:0] vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               active_out,
  output logic [7:0]         red_out,
  output logic [7:0]         green_out,
  output logic [7:0]         blue_out
);

  localparam int C_BUS_W = H_WIDTH + V_WIDTH + 3 + 24;

  logic [C_BUS_W-1:0] w_bus_in;
  logic [C_BUS_W-1:0] w_bus_a;
  logic [H_WIDTH-1:0] w_hcount_a;
  logic [V_WIDTH-1:0] w_vcount_a;
  logic               w_hsync_a;
  logic               w_vsync_a;
  logic               w_active_a;
  rgb_t               w_bg_a;
  rgb_t               w_fg;
  rgb_t               w_rgb;
  logic               w_transparent;

  comp_state_e        r_state;
  logic               r_vsync_prev;
  blend_e             r_blend_mode_q;

  logic [H_WIDTH-1:0] r_hcount;
  logic [V_WIDTH-1:0] r_vcount;
  logic               r_hsync;
  logic               r_vsync;
  logic               r_active;
  rgb_t               r_rgb;

  assign w_bus_in = {hcount_in, vcount_in, hsync_in, vsync_in, active_in, bg_rgb_in};

  pipe_delay #(
    .WIDTH  (C_BUS_W),
    .STAGES (SPRITE_LATENCY)
  ) u_align (
    .clk   (pixel_clk_in),
    .rst_n (rst_n_in),
    .i_d   (w_bus_in),
    .o_q   (w_bus_a)
  );

  assign {w_hcount_a, w_vcount_a, w_hsync_a, w_vsync_a, w_active_a, w_bg_a} = w_bus_a;
  assign w_fg          = rgb_t'(fg_rgb_in);
  assign w_transparent = key_en_in && (fg_rgb_in == key_rgb_in);

  always_comb begin
    w_rgb = '0;
    if (w_active_a) begin
      if (w_transparent) begin
        w_rgb = w_bg_a;
      end else begin
        w_rgb.r = blend_ch(w_fg.r, w_bg_a.r, r_blend_mode_q);
        w_rgb.g = blend_ch(w_fg.g, w_bg_a.g, r_blend_mode_q);
        w_rgb.b = blend_ch(w_fg.b, w_bg_a.b, r_blend_mode_q);
      end
    end
  end

  // Blend mode only changes on a vsync rise, so a frame never mixes two modes.
  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state        <= ST_IDLE;
      r_vsync_prev   <= 1'b0;
      r_blend_mode_q <= BLEND_OPAQUE;
    end else begin
      r_vsync_prev <= vsync_in;
      case (r_state)
        ST_IDLE: begin
          if (vsync_in && !r_vsync_prev) begin
            r_state        <= ST_LATCHED;
            r_blend_mode_q <= blend_e'(blend_in);
          end
        end
        ST_LATCHED: begin
          if (!vsync_in) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_hcount <= '0;
      r_vcount <= '0;
      r_hsync  <= 1'b0;
      r_vsync  <= 1'b0;
      r_active <= 1'b0;
      r_rgb    <= '0;
    end else begin
      r_hcount <= w_hcount_a;
      r_vcount <= w_vcount_a;
      r_hsync  <= w_hsync_a;
      r_vsync  <= w_vsync_a;
      r_active <= w_active_a;
      r_rgb    <= w_rgb;
    end
  end

  assign hcount_out = r_hcount;
  assign vcount_out = r_vcount;
  assign hsync_out  = r_hsync;
  assign vsync_out  = r_vsync;
  assign active_out = r_active;
  assign red_out    = r_rgb.r;
  assign green_out  = r_rgb.g;
  assign blue_out   = r_rgb.b;

endmodule
`default_nettype wire

// File: tb/tb_sprite_compositor.sv
`default_nettype none
// tb_sprite_compositor: directed vectors with hand-computed expected colours.
// Revision: 1.0
module tb_sprite_compositor;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, active, key_en;
  logic [23:0] bg, fg, key;
  logic [1:0]  blend;
  logic [10:0] hcount_out;
  logic [9:0]  vcount_out;
  logic        hsync_out, vsync_out, active_out;
  logic [7:0]  red_out, green_out, blue_out;
  logic [23:0] rgb_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign rgb_out = {red_out, green_out, blue_out};

  sprite_compositor #(
    .SPRITE_LATENCY (L),
    .H_WIDTH        (11),
    .V_WIDTH        (10)
  ) dut (
    .pixel_clk_in (clk),
    .rst_n_in     (rst_n),
    .hcount_in    (hcount),
    .vcount_in    (vcount),
    .hsync_in     (hsync),
    .vsync_in     (vsync),
    .active_in    (active),
    .bg_rgb_in    (bg),
    .fg_rgb_in    (fg),
    .key_rgb_in   (key),
    .key_en_in    (key_en),
    .blend_in     (blend),
    .hcount_out   (hcount_out),
    .vcount_out   (vcount_out),
    .hsync_out    (hsync_out),
    .vsync_out    (vsync_out),
    .active_out   (active_out),
    .red_out      (red_out),
    .green_out    (green_out),
    .blue_out     (blue_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  function automatic logic [23:0] fgpat(input int k);
    logic [7:0] r;
    r = 8'(k * 16 + 1);
    return (k == 1) ? 24'hFF0000 : {r, 8'h00, 8'h00};
  endfunction

  initial begin
    rst_n = 1'b0; hcount = '0; vcount = 10'd5; hsync = 1'b0; vsync = 1'b0;
    active = 1'b0; bg = '0; fg = '0; key = '0; key_en = 1'b0; blend = 2'b00;

    // Reset; a vsync pulse inside reset must not latch a mode.
    run(2);
    blend = 2'b10;
    vs_pulse();
    chk("rst_rgb", 32'(rgb_out), 32'h0);
    chk("rst_hcnt", 32'(hcount_out), 32'h0);
    chk("rst_active", 32'(active_out), 32'h0);
    blend = 2'b00;

    rst_n = 1'b1;
    active = 1'b1;
    for (int i = 0; i < 14; i++) begin
      hcount = 11'(i);
      tick();
      if (i < L) begin
        chk("fill_active", 32'(active_out), 32'h0);
      end else begin
        chk("fill_hcnt", 32'(hcount_out), 32'(i - L));
        chk("fill_active", 32'(active_out), 32'h1);
      end
    end
    chk("fill_vcnt", 32'(vcount_out), 32'd5);

    // fg arrives L cycles after its hcount; opaque mode returns fg exactly.
    bg = 24'h0000FF;
    for (int i = 0; i < 10; i++) begin
      hcount = 11'(200 + i);
      fg = (i >= L) ? fgpat(i - L) : 24'h0;
      tick();
      if (i >= L) begin
        chk("align_hcnt", 32'(hcount_out), 32'(200 + i - L));
        chk("align_rgb", 32'(rgb_out), 32'(fgpat(i - L)));
      end
    end

    key_en = 1'b1; key = 24'h00FF00; fg = 24'h00FF00; bg = 24'h123456;
    run(6);
    chk("key_hit", 32'(rgb_out), 32'h123456);
    fg = 24'h00FE00;
    run(6);
    chk("key_miss", 32'(rgb_out), 32'h00FE00);
    key_en = 1'b0; fg = 24'h00FF00;
    run(6);
    chk("key_off", 32'(rgb_out), 32'h00FF00);

    fg = 24'hC8C8C8; bg = 24'h646464; blend = 2'b10;
    run(6);
    chk("midframe", 32'(rgb_out), 32'hC8C8C8);
    vs_pulse();
    run(6);
    chk("blend50", 32'(rgb_out), 32'h969696);
    blend = 2'b11;
    run(6);
    chk("hold50", 32'(rgb_out), 32'h969696);
    vs_pulse();
    run(6);
    chk("blend25", 32'(rgb_out), 32'h7D7D7D);

    // Steady-high vsync must not re-latch.
    blend = 2'b01;
    vsync = 1'b1;
    tick();
    blend = 2'b00;
    run(8);
    chk("blend75", 32'(rgb_out), 32'hAFAFAF);
    vsync = 1'b0;
    run(6);
    chk("vs_steady", 32'(rgb_out), 32'hAFAFAF);
    fg = 24'h102030; bg = 24'hF0E0D0;
    run(6);
    chk("blend75_ch", 32'(rgb_out), 32'h485058);

    active = 1'b0; fg = 24'hFFFFFF;
    run(6);
    chk("inactive_rgb", 32'(rgb_out), 32'h0);
    chk("inactive_flag", 32'(active_out), 32'h0);
    active = 1'b1;

    blend = 2'b01;
    run(6);
    for (int i = 0; i < 8; i++) begin
      hsync = (i == 0);
      vsync = (i == 1);
      tick();
      chk("hsync_shift", 32'(hsync_out), 32'(i == L));
      chk("vsync_shift", 32'(vsync_out), 32'(i == L + 1));
    end

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    hcount = 11'd77; fg = 24'hC8C8C8; bg = 24'h646464;
    run(6);
    chk("pre_arst", 32'(rgb_out), 32'hAFAFAF);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_rgb", 32'(rgb_out), 32'h0);
    chk("arst_hcnt", 32'(hcount_out), 32'h0);
    chk("arst_active", 32'(active_out), 32'h0);
    #2;
    rst_n = 1'b1;
    blend = 2'b10;
    run(6);
    chk("post_arst_mode", 32'(rgb_out), 32'hC8C8C8);
    vs_pulse();
    run(6);
    chk("post_arst_vs", 32'(rgb_out), 32'h969696);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Downstream stage of the sprite renderer.
- Takes the renderer's late-arriving RGB (sprite layer) and a zero-latency background colour, and re-aligns the video timing signals to that RGB.
- Applies a colour key and a frame-synchronous blend mode, then drives registered RGB plus matching timing toward the TMDS/HDMI encoder.

Parameters:
- SPRITE_LATENCY, 4: cycles between hcount/vcount presented to the sprite renderer and its RGB arriving at fg_rgb_in. Legal range 1..8.
- H_WIDTH, 11: hcount width.
- V_WIDTH, 10: vcount width.

Ports:
- pixel_clk_in  input  1  pixel clock; the only clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- hcount_in  input  H_WIDTH  current pixel column, same cycle as given to the sprite renderer.
- vcount_in  input  V_WIDTH  current row.
- hsync_in  input  1  horizontal sync, aligned with hcount_in.
- vsync_in  input  1  vertical sync, active-high, aligned with hcount_in.
- active_in  input  1  active draw region, aligned with hcount_in.
- bg_rgb_in  input  24  background colour {R,G,B}, aligned with hcount_in.
- fg_rgb_in  input  24  sprite colour, arriving SPRITE_LATENCY cycles after hcount_in.
- key_rgb_in  input  24  transparent colour key.
- key_en_in  input  1  enable colour keying.
- blend_in  input  2  requested blend mode; sampled once per frame.
- hcount_out  output  H_WIDTH  hcount delayed by SPRITE_LATENCY+1.
- vcount_out  output  V_WIDTH  vcount delayed by SPRITE_LATENCY+1.
- hsync_out  output  1  hsync delayed by SPRITE_LATENCY+1.
- vsync_out  output  1  vsync delayed by SPRITE_LATENCY+1.
- active_out  output  1  active delayed by SPRITE_LATENCY+1.
- red_out  output  8  composited red.
- green_out  output  8  composited green.
- blue_out  output  8  composited blue.

Behaviour:
- Reset (rst_n_in low, asynchronous):
  - all delay-line stages, all outputs and blend_mode_q clear to 0.
  - Delay-line outputs read 0 until refilled, i.e. for SPRITE_LATENCY+1 cycles after release.
- Alignment:
  - hcount, vcount, hsync, vsync, active and bg_rgb pass through a SPRITE_LATENCY-deep shift register, giving stage A, which is aligned with fg_rgb_in.
  - One output register follows, so total latency is SPRITE_LATENCY+1 for every output.
- Key test (stage A): transparent = key_en_in && (fg_rgb_in == key_rgb_in). key_en_in and key_rgb_in are used unregistered at stage A.
- Blend, per 8-bit channel, fg=f and bg=b, computed with 10-bit intermediates:
  - 00: f (opaque).
  - 01: (3f+b)>>2.
  - 10: (f+b)>>1.
  - 11: (f+3b)>>2.
  - Truncate; no rounding. Results cannot exceed 255; no saturation needed.
- Composite:
  - if active_A is 0, RGB = 0;
  - else if transparent, RGB = bg_A;
  - else RGB = blend(fg, bg_A, blend_mode_q).
- Frame-synchronous mode: a 2-state FSM, IDLE and LATCHED.
  - IDLE -> LATCHED on the rising edge of vsync_in (vsync_in=1 while the previous sample was 0); blend_mode_q <= blend_in on that edge.
  - LATCHED -> IDLE when vsync_in = 0.
  - A steady-high vsync never re-latches.
  - Mid-frame changes of blend_in have no effect until the next vsync rise.
- Simultaneous events:
  - A vsync rise while reset is asserted is ignored.
  - Reset deasserting in the same cycle as a vsync rise latches normally on the next clock edge.
- Wrap-around: counts are only delayed, never modified; wrap of hcount/vcount is transparent.

Decomposition:
- Shared package video_pkg:
  - rgb_t packed struct {r,g,b} of 8 bits each;
  - blend_e enum {BLEND_OPAQUE, BLEND_75, BLEND_50, BLEND_25};
  - the comp_state_e FSM enum.
- Sub-module pipe_delay:
  - parameters WIDTH and STAGES, async active-low reset;
  - instantiated once over the concatenated {hcount, vcount, hsync, vsync, active, bg_rgb} bus.

Test Plan:
- Reset, then release and drive hcount 0..9 with active=1 -> outputs stay 0 for 5 cycles; hcount_out==0 appears on cycle 5 and increments every cycle thereafter.
- Mode 00, key_en=0, fg=0xFF0000, bg=0x0000FF, active=1 -> RGB = FF,00,00 exactly 5 cycles after the corresponding hcount.
- key_en=1, key=0x00FF00, fg=0x00FF00, bg=0x123456 -> RGB = 12,34,56. Then fg=0x00FE00 -> the opaque/blended fg path is used.
- blend_in=10 set mid-frame -> the output stays opaque. After a vsync rise, fg=0xC8C8C8 and bg=0x646464 -> RGB = 96,96,96. Under 11 -> 7D,7D,7D.
- active=0 with fg=0xFFFFFF -> RGB = 0. Also check hsync/vsync pulses reappear shifted exactly 5 cycles.
- Assert rst_n_in mid-line between clock edges -> all outputs 0 immediately, without waiting for a clock edge. After release, blend_mode returns to 00 until the next vsync rise.
